// File: rtl/mem_align_unit_pkg.sv
// Shared constants for the memory alignment unit: ALU access codes, FSM state
// encoding, access-size decode helpers.
package mem_align_unit_pkg;

    localparam int ALU_W = 6;

    localparam logic [ALU_W-1:0] ALU_LB  = 6'h10;
    localparam logic [ALU_W-1:0] ALU_LH  = 6'h11;
    localparam logic [ALU_W-1:0] ALU_LW  = 6'h12;
    localparam logic [ALU_W-1:0] ALU_LBU = 6'h13;
    localparam logic [ALU_W-1:0] ALU_LHU = 6'h14;
    localparam logic [ALU_W-1:0] ALU_SB  = 6'h18;
    localparam logic [ALU_W-1:0] ALU_SH  = 6'h19;
    localparam logic [ALU_W-1:0] ALU_SW  = 6'h1A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        DONE = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    typedef struct packed {
        logic  legal;
        logic  load;
        size_e size;
        logic  sign;
    } acc_t;

    // legal is cleared when the code does not match the single asserted access kind
    function automatic acc_t decode_acc(input logic is_load, input logic is_store,
                                        input logic [ALU_W-1:0] code);
        acc_t d;
        logic ld_ok;
        logic st_ok;
        ld_ok = is_load & ~is_store;
        st_ok = is_store & ~is_load;
        d = '{1'b0, 1'b0, SZ_B, 1'b0};
        case (code)
            ALU_LB:  d = '{ld_ok, 1'b1, SZ_B, 1'b1};
            ALU_LBU: d = '{ld_ok, 1'b1, SZ_B, 1'b0};
            ALU_LH:  d = '{ld_ok, 1'b1, SZ_H, 1'b1};
            ALU_LHU: d = '{ld_ok, 1'b1, SZ_H, 1'b0};
            ALU_LW:  d = '{ld_ok, 1'b1, SZ_W, 1'b1};
            ALU_SB:  d = '{st_ok, 1'b0, SZ_B, 1'b0};
            ALU_SH:  d = '{st_ok, 1'b0, SZ_H, 1'b0};
            ALU_SW:  d = '{st_ok, 1'b0, SZ_W, 1'b0};
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

    function automatic int size_bytes(input size_e s);
        case (s)
            SZ_B:    return 1;
            SZ_H:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic logic [3:0] size_mask(input size_e s);
        case (s)
            SZ_B:    return 4'b0001;
            SZ_H:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_align_unit_if.sv
// Request, word-indexed memory and response signals of the alignment unit.
// master = requester + memory model side, slave = mem_align_unit.
interface mem_align_unit_if import mem_align_unit_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = ADDR_W - $clog2(BYTES);

    logic              req_valid;
    logic              req_ready;
    logic              is_load;
    logic              is_store;
    logic [ALU_W-1:0]  alucode;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              mem_en;
    logic [IDX_W-1:0]  mem_addr;
    logic [BYTES-1:0]  mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic              resp_valid;
    logic              resp_err;
    logic [DATA_W-1:0] resp_rdata;

    modport master (
        output req_valid, is_load, is_store, alucode, req_addr, req_wdata, mem_rdata,
        input  req_ready, mem_en, mem_addr, mem_we, mem_wdata,
        input  resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, is_load, is_store, alucode, req_addr, req_wdata, mem_rdata,
        output req_ready, mem_en, mem_addr, mem_we, mem_wdata,
        output resp_valid, resp_err, resp_rdata
    );

endinterface

// File: rtl/mem_align_unit_lane.sv
// Merges up to two memory words, extracts the addressed byte/half/word lane
// and sign- or zero-extends it to DATA_W.
module mem_lane_extract import mem_align_unit_pkg::*; #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]               word0,
    input  logic [DATA_W-1:0]               word1,
    input  logic [$clog2(DATA_W/8)-1:0]     offset,
    input  size_e                           size,
    input  logic                            sign_ext,
    output logic [DATA_W-1:0]               data_out
);

    logic [31:0] low;

    // word1 supplies the upper bytes of an access that crosses the word boundary
    assign low = 32'({word1, word0} >> {offset, 3'b000});

    always_comb begin
        data_out = '0;
        case (size)
            SZ_B: begin
                data_out = DATA_W'(low[7:0]);
                if (sign_ext && low[7]) data_out = data_out | ~DATA_W'(8'hFF);
            end
            SZ_H: begin
                data_out = DATA_W'(low[15:0]);
                if (sign_ext && low[15]) data_out = data_out | ~DATA_W'(16'hFFFF);
            end
            SZ_W: begin
                data_out = DATA_W'(low);
                if (sign_ext && low[31]) data_out = data_out | ~DATA_W'(32'hFFFF_FFFF);
            end
            default: data_out = '0;
        endcase
    end

endmodule

// File: rtl/mem_align_unit.sv
// Byte-addressed load/store alignment onto a word-indexed memory port.
// Define MISALIGN_SPLIT_EN to split misaligned accesses into two beats; otherwise they error.
module mem_align_unit import mem_align_unit_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    mem_align_unit_if.slave bus
);
    // state | meaning
    // IDLE  | ready, waiting for a request
    // ACC0  | beat-0 memory access (or no access for an error)
    // ACC1  | beat-1 access of a split op, beat-0 read data captured
    // DONE  | one-cycle response

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = ADDR_W - OFF_W;
    localparam int WE_W  = 2 * BYTES;

    state_e            state_q, state_d;
    logic              ready_q, ready_d;
    logic              load_q, load_d;
    size_e             size_q, size_d;
    logic              sign_q, sign_d;
    logic              err_q, err_d;
    logic              split_q, split_d;
    logic [OFF_W-1:0]  off_q, off_d;
    logic [BYTES-1:0]  we_hi_q, we_hi_d;
    logic [DATA_W-1:0] wd_hi_q, wd_hi_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              mem_en_q, mem_en_d;
    logic [IDX_W-1:0]  mem_addr_q, mem_addr_d;
    logic [BYTES-1:0]  mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;

    acc_t                req_dec;
    logic [OFF_W-1:0]    req_off;
    logic                req_mis;
    logic                req_err;
    logic                req_split;
    logic [WE_W-1:0]     req_we_wide;
    logic [2*DATA_W-1:0] req_wd_wide;
    logic [DATA_W-1:0]   ext_word0, ext_word1, ext_data;

    assign req_dec     = decode_acc(bus.is_load, bus.is_store, bus.alucode);
    assign req_off     = bus.req_addr[OFF_W-1:0];
    assign req_mis     = (int'(req_off) + size_bytes(req_dec.size)) > BYTES;
    assign req_we_wide = WE_W'(size_mask(req_dec.size)) << req_off;
    assign req_wd_wide = (2*DATA_W)'(bus.req_wdata) << {req_off, 3'b000};

`ifdef MISALIGN_SPLIT_EN
    assign req_err   = !req_dec.legal;
    assign req_split = req_dec.legal && req_mis;
`else
    assign req_err   = !req_dec.legal || req_mis;
    assign req_split = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        load_d       = load_q;
        size_d       = size_q;
        sign_d       = sign_q;
        err_d        = err_q;
        split_d      = split_q;
        off_d        = off_q;
        we_hi_d      = we_hi_q;
        wd_hi_d      = wd_hi_q;
        hold_d       = hold_q;
        mem_en_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_we_d     = '0;
        mem_wdata_d  = '0;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;

        // memory-port outputs are registered, so they are set on entry to the state that shows them
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid && ready_q) begin
                    state_d    = ACC0;
                    load_d     = req_dec.load;
                    size_d     = req_dec.size;
                    sign_d     = req_dec.sign;
                    err_d      = req_err;
                    split_d    = req_split;
                    off_d      = req_off;
                    we_hi_d    = req_we_wide[WE_W-1:BYTES];
                    wd_hi_d    = req_wd_wide[2*DATA_W-1:DATA_W];
                    mem_addr_d = bus.req_addr[ADDR_W-1:OFF_W];
                    if (!req_err) begin
                        mem_en_d = 1'b1;
                        if (!req_dec.load) begin
                            mem_we_d    = req_we_wide[BYTES-1:0];
                            mem_wdata_d = req_wd_wide[DATA_W-1:0];
                        end
                    end
                end
            end
            ACC0: begin
                if (split_q) begin
                    state_d    = ACC1;
                    mem_en_d   = 1'b1;
                    mem_addr_d = mem_addr_q + IDX_W'(1);
                    if (!load_q) begin
                        mem_we_d    = we_hi_q;
                        mem_wdata_d = wd_hi_q;
                    end
                end else begin
                    state_d      = DONE;
                    resp_valid_d = 1'b1;
                    resp_err_d   = err_q;
                end
            end
            ACC1: begin
                hold_d       = bus.mem_rdata;
                state_d      = DONE;
                resp_valid_d = 1'b1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            load_q       <= 1'b0;
            size_q       <= SZ_B;
            sign_q       <= 1'b0;
            err_q        <= 1'b0;
            split_q      <= 1'b0;
            off_q        <= '0;
            we_hi_q      <= '0;
            wd_hi_q      <= '0;
            hold_q       <= '0;
            mem_en_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_we_q     <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_q      <= ready_d;
            load_q       <= load_d;
            size_q       <= size_d;
            sign_q       <= sign_d;
            err_q        <= err_d;
            split_q      <= split_d;
            off_q        <= off_d;
            we_hi_q      <= we_hi_d;
            wd_hi_q      <= wd_hi_d;
            hold_q       <= hold_d;
            mem_en_q     <= mem_en_d;
            mem_addr_q   <= mem_addr_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // the memory samples en/we at the same edge that applies reset, so gate them with rst
    assign bus.mem_en     = mem_en_q & ~rst;
    assign bus.mem_we     = rst ? '0 : mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;

    // read data arrives in the DONE cycle itself, so the load result is not registered
    assign ext_word0 = split_q ? hold_q : bus.mem_rdata;
    assign ext_word1 = split_q ? bus.mem_rdata : '0;

    mem_lane_extract #(.DATA_W(DATA_W)) u_lane_extract (
        .word0    (ext_word0),
        .word1    (ext_word1),
        .offset   (off_q),
        .size     (size_q),
        .sign_ext (sign_q),
        .data_out (ext_data)
    );

    assign bus.resp_rdata = (state_q == DONE && load_q && !err_q) ? ext_data : '0;

endmodule
